// File: rtl/mc_req_arbiter.sv
// Memory-request arbiter for the SpMV engine: shares one coprocessor request port
// between RAM preload, A-stream, X-gather loads and Y stores, with read credits and drain.
module mc_req_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 64,
    parameter int unsigned CREDIT_W        = 8,
    parameter int unsigned STARVE_LIMIT    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ram_req_valid,
    input  logic [47:0]         ram_req_vadr,
    output logic                ram_req_ready,
    input  logic                a_req_valid,
    input  logic [47:0]         a_req_vadr,
    output logic                a_req_ready,
    input  logic                x_req_valid,
    input  logic [47:0]         x_req_vadr,
    input  logic [4:0]          x_req_count,
    output logic                x_req_ready,
    input  logic                st_req_valid,
    input  logic [47:0]         st_req_vadr,
    input  logic [63:0]         st_req_data,
    output logic                st_req_ready,
    input  logic                drain,
    input  logic                mc_rd_rq_stall,
    input  logic                mc_wr_rq_stall,
    input  logic                mc_rsp_push,
    input  logic [31:0]         mc_rsp_rdctl,
    output logic                mc_req_ld,
    output logic                mc_req_st,
    output logic [47:0]         mc_req_vadr,
    output logic [63:0]         mc_req_wrd_rdctl,
    output logic [CREDIT_W-1:0] outstanding,
    output logic                drained,
    output logic                err_underflow
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned          SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CREDIT_W-1:0]  MAX_CRED   = CREDIT_W'(MAX_OUTSTANDING);
    localparam logic [SW-1:0]        STARVE_MAX = SW'(STARVE_LIMIT);

    state_t               state, state_nx;
    logic [1:0]           rr_ptr, rr_nx;
    logic [SW-1:0]        starve_cnt, starve_nx;
    logic                 ld_ok, any_ld, st_elig, st_grant, ld_grant, rsp_dec;
    logic [2:0]           ld_elig, ld_onehot;
    logic [1:0]           ld_sel;
    logic [CREDIT_W-1:0]  out_nx;
    logic                 err_nx;
    logic [47:0]          vadr_nx;
    logic [63:0]          wrd_nx;
    logic                 unused_rdctl;

    // Only the response-class bits matter for credit return.
    assign unused_rdctl = ^mc_rsp_rdctl[31:2];

    always_comb begin
        // Readies are forced low while reset is held.
        ld_ok    = reset && !mc_rd_rq_stall && (outstanding < MAX_CRED) && (state == RUN);
        ld_elig  = {x_req_valid, a_req_valid, ram_req_valid} & {3{ld_ok}};
        any_ld   = |ld_elig;
        st_elig  = reset && st_req_valid && !mc_wr_rq_stall;
        st_grant = st_elig && !((starve_cnt == STARVE_MAX) && any_ld);
        ld_grant = any_ld && !st_grant;

        case (rr_ptr)
            2'd1:    ld_sel = ld_elig[1] ? 2'd1 : (ld_elig[2] ? 2'd2 : 2'd0);
            2'd2:    ld_sel = ld_elig[2] ? 2'd2 : (ld_elig[0] ? 2'd0 : 2'd1);
            default: ld_sel = ld_elig[0] ? 2'd0 : (ld_elig[1] ? 2'd1 : 2'd2);
        endcase

        ld_onehot = '0;
        if (ld_grant) ld_onehot[ld_sel] = 1'b1;

        rr_nx = rr_ptr;
        if (ld_grant) rr_nx = (ld_sel == 2'd2) ? 2'd0 : ld_sel + 2'd1;

        starve_nx = starve_cnt;
        if (ld_grant || !any_ld)
            starve_nx = '0;
        else if (st_grant && (starve_cnt != STARVE_MAX))
            starve_nx = starve_cnt + 1'b1;

        rsp_dec = mc_rsp_push && (mc_rsp_rdctl[1:0] != 2'b11);
        out_nx  = outstanding;
        err_nx  = err_underflow;
        if (ld_grant && !rsp_dec) begin
            out_nx = outstanding + 1'b1;
        end else if (!ld_grant && rsp_dec) begin
            if (outstanding == '0) err_nx = 1'b1;
            else                   out_nx = outstanding - 1'b1;
        end

        vadr_nx = '0;
        wrd_nx  = '0;
        if (st_grant) begin
            vadr_nx = st_req_vadr;
            wrd_nx  = st_req_data;
        end else if (ld_onehot[0]) begin
            vadr_nx = ram_req_vadr;
            wrd_nx  = 64'h2;
        end else if (ld_onehot[1]) begin
            vadr_nx = a_req_vadr;
            wrd_nx  = 64'h0;
        end else if (ld_onehot[2]) begin
            vadr_nx = x_req_vadr;
            wrd_nx  = {57'h0, x_req_count, 2'h1};
        end

        state_nx = state;
        case (state)
            RUN:     if (drain) state_nx = DRAIN;
            DRAIN:   if (!drain) state_nx = RUN;
                     else if ((outstanding == '0) && !mc_req_ld) state_nx = DONE;
            DONE:    if (!drain) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    assign ram_req_ready = ld_onehot[0];
    assign a_req_ready   = ld_onehot[1];
    assign x_req_ready   = ld_onehot[2];
    assign st_req_ready  = st_grant;
    assign drained       = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= RUN;
            rr_ptr           <= 2'd0;
            starve_cnt       <= '0;
            outstanding      <= '0;
            err_underflow    <= 1'b0;
            mc_req_ld        <= 1'b0;
            mc_req_st        <= 1'b0;
            mc_req_vadr      <= '0;
            mc_req_wrd_rdctl <= '0;
        end else begin
            state            <= state_nx;
            rr_ptr           <= rr_nx;
            starve_cnt       <= starve_nx;
            outstanding      <= out_nx;
            err_underflow    <= err_nx;
            mc_req_ld        <= ld_grant;
            mc_req_st        <= st_grant;
            mc_req_vadr      <= vadr_nx;
            mc_req_wrd_rdctl <= wrd_nx;
        end
    end

endmodule

// File: tb/tb_mc_req_arbiter.sv
// Directed self-checking bench for mc_req_arbiter with hand-computed expectations.
module tb_mc_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_req_valid, a_req_valid, x_req_valid, st_req_valid;
    logic [47:0] ram_req_vadr, a_req_vadr, x_req_vadr, st_req_vadr;
    logic [4:0]  x_req_count;
    logic [63:0] st_req_data;
    logic        ram_req_ready, a_req_ready, x_req_ready, st_req_ready;
    logic        drain, mc_rd_rq_stall, mc_wr_rq_stall, mc_rsp_push;
    logic [31:0] mc_rsp_rdctl;
    logic        mc_req_ld, mc_req_st;
    logic [47:0] mc_req_vadr;
    logic [63:0] mc_req_wrd_rdctl;
    logic [7:0]  outstanding;
    logic        drained, err_underflow;

    int total = 0;
    int bad   = 0;

    mc_req_arbiter #(
        .MAX_OUTSTANDING(64),
        .CREDIT_W(8),
        .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .ram_req_valid(ram_req_valid), .ram_req_vadr(ram_req_vadr), .ram_req_ready(ram_req_ready),
        .a_req_valid(a_req_valid), .a_req_vadr(a_req_vadr), .a_req_ready(a_req_ready),
        .x_req_valid(x_req_valid), .x_req_vadr(x_req_vadr), .x_req_count(x_req_count),
        .x_req_ready(x_req_ready),
        .st_req_valid(st_req_valid), .st_req_vadr(st_req_vadr), .st_req_data(st_req_data),
        .st_req_ready(st_req_ready),
        .drain(drain), .mc_rd_rq_stall(mc_rd_rq_stall), .mc_wr_rq_stall(mc_wr_rq_stall),
        .mc_rsp_push(mc_rsp_push), .mc_rsp_rdctl(mc_rsp_rdctl),
        .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st), .mc_req_vadr(mc_req_vadr),
        .mc_req_wrd_rdctl(mc_req_wrd_rdctl), .outstanding(outstanding),
        .drained(drained), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ram_req_valid = 1'b1; ram_req_vadr = 48'h1000;
        a_req_valid = 1'b0;   a_req_vadr = 48'h2000;
        x_req_valid = 1'b0;   x_req_vadr = 48'h3000; x_req_count = 5'd5;
        st_req_valid = 1'b0;  st_req_vadr = 48'h4000; st_req_data = 64'hDEADBEEF;
        drain = 1'b0; mc_rd_rq_stall = 1'b0; mc_wr_rq_stall = 1'b0;
        mc_rsp_push = 1'b0; mc_rsp_rdctl = 32'h0;

        // Reset state, with a request pending
        tick(); tick();
        chk("rst_ram_ready", 64'(ram_req_ready), 64'h0);
        chk("rst_ld", 64'(mc_req_ld), 64'h0);
        chk("rst_st", 64'(mc_req_st), 64'h0);
        chk("rst_vadr", 64'(mc_req_vadr), 64'h0);
        chk("rst_wrd", mc_req_wrd_rdctl, 64'h0);
        chk("rst_out", 64'(outstanding), 64'h0);
        chk("rst_drained", 64'(drained), 64'h0);
        chk("rst_err", 64'(err_underflow), 64'h0);

        // RAM loads back to back
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            settle();
            chk("ram_ready", 64'(ram_req_ready), 64'h1);
            tick();
            chk("ram_ld", 64'(mc_req_ld), 64'h1);
            chk("ram_vadr", 64'(mc_req_vadr), 64'h1000);
            chk("ram_wrd", mc_req_wrd_rdctl, 64'h2);
            chk("ram_out", 64'(outstanding), 64'(i));
        end
        ram_req_valid = 1'b0;
        tick();
        chk("idle_ld", 64'(mc_req_ld), 64'h0);
        chk("idle_vadr", 64'(mc_req_vadr), 64'h0);
        chk("idle_wrd", mc_req_wrd_rdctl, 64'h0);

        // A / X round robin (pointer sits at A after the RAM grants)
        a_req_valid = 1'b1; x_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_a_ready", 64'(a_req_ready), (i % 2 == 0) ? 64'h1 : 64'h0);
            chk("rr_x_ready", 64'(x_req_ready), (i % 2 == 1) ? 64'h1 : 64'h0);
            tick();
            chk("rr_vadr", 64'(mc_req_vadr), (i % 2 == 0) ? 64'h2000 : 64'h3000);
            chk("rr_wrd", mc_req_wrd_rdctl, (i % 2 == 0) ? 64'h0 : 64'h15);
            chk("rr_out", 64'(outstanding), 64'(4 + i));
        end
        a_req_valid = 1'b0; x_req_valid = 1'b0;

        // Response with class 3 returns no credit; then return all 7
        mc_rsp_push = 1'b1; mc_rsp_rdctl = 32'h3;
        tick();
        chk("rsp_cls3_out", 64'(outstanding), 64'd7);
        mc_rsp_rdctl = 32'h0;
        for (int i = 0; i < 7; i++) tick();
        mc_rsp_push = 1'b0;
        chk("rsp_ret_out", 64'(outstanding), 64'd0);

        // Store vs A: 8 stores then one A, repeating
        st_req_valid = 1'b1; a_req_valid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            settle();
            chk("stv_st_ready", 64'(st_req_ready), (k % 9 == 8) ? 64'h0 : 64'h1);
            chk("stv_a_ready", 64'(a_req_ready), (k % 9 == 8) ? 64'h1 : 64'h0);
            tick();
            chk("stv_mc_st", 64'(mc_req_st), (k % 9 == 8) ? 64'h0 : 64'h1);
            chk("stv_wrd", mc_req_wrd_rdctl, (k % 9 == 8) ? 64'h0 : 64'hDEADBEEF);
        end
        st_req_valid = 1'b0; a_req_valid = 1'b0;
        chk("stv_out", 64'(outstanding), 64'd2);
        mc_rsp_push = 1'b1;
        tick(); tick();
        mc_rsp_push = 1'b0;
        chk("stv_ret_out", 64'(outstanding), 64'd0);

        // Credit limit
        ram_req_valid = 1'b1;
        for (int i = 0; i < 64; i++) tick();
        chk("cred_full", 64'(outstanding), 64'd64);
        settle();
        chk("cred_block_ready", 64'(ram_req_ready), 64'h0);
        tick();
        chk("cred_block_ld", 64'(mc_req_ld), 64'h0);
        mc_rsp_push = 1'b1;
        tick();
        mc_rsp_push = 1'b0;
        chk("cred_63", 64'(outstanding), 64'd63);
        settle();
        chk("cred_reopen", 64'(ram_req_ready), 64'h1);
        mc_rsp_push = 1'b1;
        tick();
        mc_rsp_push = 1'b0;
        chk("cred_both_out", 64'(outstanding), 64'd63);
        chk("cred_both_ld", 64'(mc_req_ld), 64'h1);
        tick();
        chk("cred_refill", 64'(outstanding), 64'd64);
        ram_req_valid = 1'b0;
        mc_rsp_push = 1'b1;
        for (int i = 0; i < 61; i++) tick();
        mc_rsp_push = 1'b0;
        chk("cred_to3", 64'(outstanding), 64'd3);

        // Drain
        drain = 1'b1;
        tick();
        chk("drn_enter", 64'(drained), 64'h0);
        ram_req_valid = 1'b1;
        settle();
        chk("drn_no_ld", 64'(ram_req_ready), 64'h0);
        mc_rsp_push = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick();
            chk("drn_out", 64'(outstanding), 64'(i));
            chk("drn_not_yet", 64'(drained), 64'h0);
        end
        mc_rsp_push = 1'b0;
        tick();
        chk("drn_done", 64'(drained), 64'h1);
        chk("drn_done_ready", 64'(ram_req_ready), 64'h0);
        st_req_valid = 1'b1;
        settle();
        chk("drn_st_ready", 64'(st_req_ready), 64'h1);
        tick();
        st_req_valid = 1'b0;
        chk("drn_st_out", 64'(mc_req_st), 64'h1);
        drain = 1'b0;
        tick();
        chk("drn_exit", 64'(drained), 64'h0);
        mc_rd_rq_stall = 1'b1;
        settle();
        chk("stall_ready", 64'(ram_req_ready), 64'h0);
        mc_rd_rq_stall = 1'b0;
        settle();
        chk("resume_ready", 64'(ram_req_ready), 64'h1);
        tick();
        ram_req_valid = 1'b0;
        chk("resume_ld", 64'(mc_req_ld), 64'h1);
        chk("resume_out", 64'(outstanding), 64'd1);
        mc_rsp_push = 1'b1;
        tick();
        mc_rsp_push = 1'b0;
        chk("resume_ret", 64'(outstanding), 64'd0);

        // Underflow
        mc_rsp_push = 1'b1;
        tick();
        mc_rsp_push = 1'b0;
        chk("uf_out", 64'(outstanding), 64'd0);
        chk("uf_err", 64'(err_underflow), 64'h1);
        tick();
        chk("uf_sticky", 64'(err_underflow), 64'h1);

        // Reset mid-stream
        ram_req_valid = 1'b1;
        tick();
        chk("mid_ld", 64'(mc_req_ld), 64'h1);
        reset = 1'b0;
        settle();
        chk("mid_rst_ready", 64'(ram_req_ready), 64'h0);
        tick();
        chk("mid_rst_ld", 64'(mc_req_ld), 64'h0);
        chk("mid_rst_vadr", 64'(mc_req_vadr), 64'h0);
        chk("mid_rst_wrd", mc_req_wrd_rdctl, 64'h0);
        chk("mid_rst_out", 64'(outstanding), 64'h0);
        chk("mid_rst_err", 64'(err_underflow), 64'h0);
        chk("mid_rst_drained", 64'(drained), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_req_arbiter.md
Name: mc_req_arbiter

Overview:
- Shares the single coprocessor memory-request port between the four request sources of the sparse matrix-vector engine:
  - MCV RAM preload
  - A-stream packet loads
  - X-vector gather loads
  - Y result stores
- Tags each load with the response-class code in rdctl[1:0], so response steering downstream stays correct.
- Limits in-flight reads with a credit counter.
- Provides a drain sequence so the engine's controller can tell when all responses have returned before it goes idle.

Parameters:
- MAX_OUTSTANDING, 64: maximum in-flight loads before load grants stop.
- CREDIT_W, 8: width of the outstanding-read counter; must hold MAX_OUTSTANDING.
- STARVE_LIMIT, 8: number of consecutive store grants allowed while a load is eligible before loads take priority.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- ram_req_valid  in  1  MCV RAM load request
- ram_req_vadr  in  48  address for the MCV RAM load
- ram_req_ready  out  1  grant for the MCV RAM load
- a_req_valid  in  1  A-stream load request
- a_req_vadr  in  48  address for the A-stream load
- a_req_ready  out  1  grant for the A-stream load
- x_req_valid  in  1  X gather load request
- x_req_vadr  in  48  address for the X gather load
- x_req_count  in  5  run count carried in rdctl[6:2]
- x_req_ready  out  1  grant for the X gather load
- st_req_valid  in  1  result store request
- st_req_vadr  in  48  address for the result store
- st_req_data  in  64  store data
- st_req_ready  out  1  grant for the result store
- drain  in  1  level: stop issuing loads and wait for all responses
- mc_rd_rq_stall  in  1  memory controller read stall
- mc_wr_rq_stall  in  1  memory controller write stall
- mc_rsp_push  in  1  memory response valid
- mc_rsp_rdctl  in  32  memory response tag
- mc_req_ld  out  1  registered load strobe
- mc_req_st  out  1  registered store strobe
- mc_req_vadr  out  48  registered request address
- mc_req_wrd_rdctl  out  64  registered store data or read tag
- outstanding  out  CREDIT_W  current in-flight load count
- drained  out  1  drain sequence complete
- err_underflow  out  1  sticky: response arrived with zero outstanding

Behaviour:
- Handshake:
  - X_req_ready is combinational, is a function of current state and inputs, and is one-hot or all zero.
  - A transfer happens when valid && ready.
  - Requesters hold valid, address and data stable until the transfer.
- Output register:
  - The granted request appears on mc_req_* in the following cycle: exactly 1-cycle latency.
  - When there is no grant, mc_req_ld and mc_req_st are 0 and vadr/wrd_rdctl are 0.
- Read tags, carried in mc_req_wrd_rdctl:
  - RAM: 64'h2.
  - A-stream: 64'h0.
  - X gather: {57'h0, x_req_count, 2'h1}.
  - Store: st_req_data.
- Eligibility:
  - Store is eligible when st_req_valid && !mc_wr_rq_stall.
  - A load is eligible when its valid is high && !mc_rd_rq_stall && outstanding < MAX_OUTSTANDING && state == RUN.
  - The stall and credit checks use the current-cycle inputs.
- Priority:
  - An eligible store wins, unless starve_cnt == STARVE_LIMIT and some load is eligible; in that case the load wins.
  - Loads are granted round-robin in the order RAM, A, X. The pointer moves to the position after the winner, and only on a load grant.
- starve_cnt:
  - Increments on a store grant while any load is eligible.
  - Clears on any load grant, or when no load is eligible.
  - Saturates at STARVE_LIMIT.
- outstanding counter:
  - +1 on a load grant.
  - -1 on mc_rsp_push with mc_rsp_rdctl[1:0] != 3.
  - Both in the same cycle: unchanged.
  - A decrement at 0 holds the counter at 0 and sets err_underflow, which stays set until reset.
- States (2-bit):
  - RUN: normal operation. drain=1 -> DRAIN.
  - DRAIN: no load grants; stores are still granted. When outstanding == 0 and no load grant is in the output register -> DONE.
  - DONE: drained=1; stores are still granted. drain=0 -> RUN.
  - drain deasserted while in DRAIN -> RUN.
- Reset (reset == 0 at a clk edge):
  - state=RUN, outstanding=0, starve_cnt=0, rr pointer=RAM.
  - All mc_req_* = 0, drained=0, err_underflow=0, all ready=0.
  - Reset in the middle of traffic discards the credits of in-flight reads. Responses that arrive after reset are absorbed by the underflow rule, which flags them.
- A stall that asserts in the same cycle as a would-be grant blocks the grant. A request already registered is not retracted.

Test Plan:
- Reset, then ram_req_valid held high with vadr=0x1000, no stalls -> ram_req_ready=1 every cycle; mc_req_ld=1, vadr=0x1000, wrd_rdctl=2 one cycle later; outstanding counts 1,2,3...
- A and X valid continuously, x_req_count=5, vadr=0x2000/0x3000 -> grants alternate A,X,A,X; X requests carry wrd_rdctl=0x15.
- Store and A both valid every cycle, STARVE_LIMIT=8 -> 8 store grants, then 1 A grant, repeating; st data 0xDEADBEEF appears on wrd_rdctl with mc_req_st=1.
- 64 loads issued with no responses -> load ready drops at outstanding=64; one response with rdctl=0 -> 63, and one load grant the next cycle; a push and a grant in the same cycle leave the count unchanged.
- drain=1 with outstanding=3, then 3 responses -> no load grants, drained=1 the cycle after the count reaches 0; drain=0 -> RUN and loads resume.
- mc_rsp_push with outstanding=0 -> outstanding stays 0 and err_underflow=1 until reset; reset asserted mid-stream -> all outputs 0 on the next edge.
